// File: rtl/switch_output_port_pkg.sv
// Shared types for the switch output port egress buffer: RAM entry layout and read-side FSM states.
package switch_output_pkg;
  localparam int DEFAULT_DEPTH = 64;

  typedef struct packed {
    logic       last;
    logic [7:0] data;
  } sop_entry_t;

  typedef enum logic [1:0] {IDLE, AVAIL, GAP} sop_state_t;
endpackage

// File: rtl/switch_output_port_if.sv
// Core-side byte stream plus consumer-side pop/status signals of one switch output port.
interface switch_output_port_if #(parameter int CNT_W = 7);
  logic             in_valid;
  logic [7:0]       in_data;
  logic             in_last;
  logic             in_ready;
  logic [7:0]       data_out;
  logic             ready;
  logic             read;
  logic [CNT_W-1:0] pkt_count;
  logic [15:0]      drop_count;

  modport master (output in_valid, in_data, in_last, read,
                  input  in_ready, data_out, ready, pkt_count, drop_count);
  modport slave  (input  in_valid, in_data, in_last, read,
                  output in_ready, data_out, ready, pkt_count, drop_count);
endinterface

// File: rtl/switch_output_port_buf.sv
// Entry RAM with read, tentative-write and committed-write pointers; rewind discards the open packet.
module switch_output_buf
  import switch_output_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       wr_en,
  input  sop_entry_t wr_entry,
  input  logic       commit,
  input  logic       rewind,
  input  logic       rd_en,
  output sop_entry_t rd_entry,
  output logic       full
);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

  sop_entry_t      mem_q [DEPTH];
  logic [ADDR_W:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d, cm_ptr_q, cm_ptr_d;

  // RAM needs no reset: the pointers define what is valid.
  always_ff @(posedge clock)
    if (wr_en) mem_q[wr_ptr_q[ADDR_W-1:0]] <= wr_entry;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cm_ptr_d = cm_ptr_q;
    if (rd_en)       rd_ptr_d = rd_ptr_q + ONE;
    if (rewind)      wr_ptr_d = cm_ptr_q;
    else if (wr_en)  wr_ptr_d = wr_ptr_q + ONE;
    if (commit)      cm_ptr_d = wr_ptr_q + ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cm_ptr_q <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cm_ptr_q <= cm_ptr_d;
    end
  end

  assign rd_entry = mem_q[rd_ptr_q[ADDR_W-1:0]];
  assign full     = (wr_ptr_q - rd_ptr_q) == FULL;
endmodule

// File: rtl/switch_output_port.sv
// Store-and-forward egress port: commits whole packets, offers them with a 1-cycle gap between packets.
// Optional parity drop enabled by SWITCH_OUTPUT_PORT_PARITY_EN.
module switch_output_port
  import switch_output_pkg::*;
#(
  parameter int DEPTH  = DEFAULT_DEPTH,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = $clog2(DEPTH+1)
) (
  input logic                 clock,
  input logic                 reset,
  switch_output_port_if.slave bus
);
  sop_entry_t       rd_entry;
  sop_state_t       state_q, state_d;
  logic [CNT_W-1:0] pkt_count_q, pkt_count_d;
  logic [7:0]       data_out_q, data_out_d;
  logic             full, accept, pop, pop_last, commit, rewind;

  assign bus.in_ready = !full;
  assign accept       = bus.in_valid && !full;
  assign pop          = bus.read && (state_q == AVAIL);
  assign pop_last     = pop && rd_entry.last;

`ifdef SWITCH_OUTPUT_PORT_PARITY_EN
  logic [7:0]  par_q, par_d;
  logic [15:0] drop_q, drop_d;
  logic        par_bad;

  // Parity covers the whole packet including its final byte, so a good packet XORs to zero.
  assign par_bad = (par_q ^ bus.in_data) != 8'h00;
  assign commit  = accept && bus.in_last && !par_bad;
  assign rewind  = accept && bus.in_last && par_bad;

  always_comb begin
    par_d  = par_q;
    drop_d = drop_q;
    if (accept) par_d = bus.in_last ? 8'h00 : (par_q ^ bus.in_data);
    if (rewind && drop_q != 16'hFFFF) drop_d = drop_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      par_q  <= '0;
      drop_q <= '0;
    end else begin
      par_q  <= par_d;
      drop_q <= drop_d;
    end
  end

  assign bus.drop_count = drop_q;
`else
  assign commit         = accept && bus.in_last;
  assign rewind         = 1'b0;
  assign bus.drop_count = 16'h0000;
`endif

  switch_output_buf #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_buf (
    .clock    (clock),
    .reset    (reset),
    .wr_en    (accept),
    .wr_entry ('{last: bus.in_last, data: bus.in_data}),
    .commit   (commit),
    .rewind   (rewind),
    .rd_en    (pop),
    .rd_entry (rd_entry),
    .full     (full)
  );

  always_comb begin
    pkt_count_d = pkt_count_q;
    data_out_d  = data_out_q;
    state_d     = state_q;
    case ({commit, pop_last})
      2'b10:   pkt_count_d = pkt_count_q + CNT_W'(1);
      2'b01:   pkt_count_d = pkt_count_q - CNT_W'(1);
      default: pkt_count_d = pkt_count_q;
    endcase
    if (pop) data_out_d = rd_entry.data;
    case (state_q)
      IDLE:    if (pkt_count_d != '0) state_d = AVAIL;
      // Leaving AVAIL on a last-byte pop forces the inter-packet gap even with read held.
      AVAIL:   if (pop_last) state_d = GAP;
               else if (pkt_count_d == '0) state_d = IDLE;
      GAP:     state_d = (pkt_count_d != '0) ? AVAIL : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      pkt_count_q <= '0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      pkt_count_q <= pkt_count_d;
      data_out_q  <= data_out_d;
    end
  end

  assign bus.ready     = (state_q == AVAIL);
  assign bus.data_out  = data_out_q;
  assign bus.pkt_count = pkt_count_q;

  // A full buffer with nothing committed means one packet exceeds DEPTH bytes.
  a_pkt_too_long: assert property (@(posedge clock) disable iff (reset)
                                   !(full && pkt_count_q == '0));
endmodule
